// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router input: buffers a payload, then emits
// header, payload and parity beats under router busy back-pressure.
module router_pkt_tx #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_addr,
  input  logic [5:0]       cmd_len,
  input  logic             pl_valid,
  output logic             pl_ready,
  input  logic [7:0]       pl_data,
  input  logic             busy,
  output logic             pkt_valid,
  output logic [7:0]       data_out,
  output logic             tx_active,
  output logic             cmd_err,
  output logic [6:0]       fifo_count,
  output logic [CNT_W-1:0] pkt_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [6:0] DEPTH_C = 7'(DEPTH);

  typedef enum logic [2:0] {IDLE, WAIT_DATA, HEADER, PAYLOAD, PARITY, GAP} state_t;

  state_t          state;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [1:0]      addr_reg;
  logic [5:0]      len_reg;
  logic [5:0]      remaining;
  logic [7:0]      parity;
  logic            push;
  logic            pop;

  assign pl_ready  = (fifo_count < DEPTH_C);
  assign push      = pl_valid & pl_ready;
  // WAIT_DATA guarantees len bytes are buffered, so pops never underflow
  assign pop       = ((state == HEADER) || (state == PAYLOAD)) && !busy && (remaining != 6'd0);
  assign cmd_ready = (state == IDLE);
  assign tx_active = (state == HEADER) || (state == PAYLOAD) || (state == PARITY) || (state == GAP);

  // Storage needs no reset: emptiness is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= pl_data;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      addr_reg   <= '0;
      len_reg    <= '0;
      remaining  <= '0;
      parity     <= '0;
      pkt_valid  <= 1'b0;
      data_out   <= '0;
      cmd_err    <= 1'b0;
      pkt_count  <= '0;
    end else begin
      cmd_err <= 1'b0;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + {6'd0, push} - {6'd0, pop};

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_addr == 2'd3 || cmd_len == 6'd0) begin
              cmd_err <= 1'b1;
            end else begin
              addr_reg <= cmd_addr;
              len_reg  <= cmd_len;
              state    <= WAIT_DATA;
            end
          end
        end
        WAIT_DATA: begin
          if (fifo_count >= {1'b0, len_reg}) begin
            data_out  <= {len_reg, addr_reg};
            parity    <= {len_reg, addr_reg};
            pkt_valid <= 1'b1;
            remaining <= len_reg;
            state     <= HEADER;
          end
        end
        HEADER, PAYLOAD: begin
          if (!busy) begin
            if (remaining != 6'd0) begin
              data_out  <= mem[rd_ptr];
              parity    <= parity ^ mem[rd_ptr];
              remaining <= remaining - 6'd1;
              state     <= PAYLOAD;
            end else begin
              data_out  <= parity;
              pkt_valid <= 1'b0;
              state     <= PARITY;
            end
          end
        end
        PARITY: begin
          if (!busy) begin
            data_out  <= '0;
            pkt_count <= pkt_count + CNT_W'(1);
            state     <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: linear steps with immediate assertions
// against hand-computed beats.
module tb_router_pkt_tx;

  logic        clock = 1'b0;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_addr;
  logic [5:0]  cmd_len;
  logic        pl_valid;
  logic        pl_ready;
  logic [7:0]  pl_data;
  logic        busy;
  logic        pkt_valid;
  logic [7:0]  data_out;
  logic        tx_active;
  logic        cmd_err;
  logic [6:0]  fifo_count;
  logic [15:0] pkt_count;

  int tests  = 0;
  int failed = 0;

  logic [7:0] bytes_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] par_q[$];
  logic [7:0] p1[63];
  logic [7:0] p2[63];
  logic [7:0] b4[4];

  router_pkt_tx #(.DEPTH(64), .CNT_W(16)) dut (
    .clock(clock), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
    .busy(busy), .pkt_valid(pkt_valid), .data_out(data_out),
    .tx_active(tx_active), .cmd_err(cmd_err), .fifo_count(fifo_count), .pkt_count(pkt_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic push_byte(input logic [7:0] b);
    pl_valid = 1'b1;
    pl_data  = b;
    tick();
    pl_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] a, input logic [5:0] l);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Header is already on data_out; walk payload, parity, gap with busy=0.
  task automatic beats(input string tag, input logic [7:0] hdr);
    logic [7:0] par;
    check({tag, "_hdr"}, data_out, hdr);
    check({tag, "_hdr_pv"}, pkt_valid, 1);
    par = hdr;
    foreach (bytes_q[i]) begin
      tick();
      check({tag, "_pl"}, data_out, bytes_q[i]);
      check({tag, "_pl_pv"}, pkt_valid, 1);
      par = par ^ bytes_q[i];
    end
    tick();
    check({tag, "_par"}, data_out, par);
    check({tag, "_par_pv"}, pkt_valid, 0);
    tick();
    check({tag, "_gap_data"}, data_out, 0);
    check({tag, "_gap_active"}, tx_active, 1);
    tick();
    check({tag, "_idle_active"}, tx_active, 0);
  endtask

  initial begin
    resetn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    pl_valid = 1'b0; pl_data = '0; busy = 1'b0;
    for (int i = 0; i < 63; i++) begin
      p1[i] = 8'(i + 1);
      p2[i] = 8'hC0 ^ 8'(i);
    end
    b4 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    repeat (2) @(negedge clock);
    check("rst_pkt_valid", pkt_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_tx_active", tx_active, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_pl_ready", pl_ready, 1);
    resetn = 1'b1;
    tick();

    // No back-pressure: header {3,1}=0x0D, parity 0x0D^0x11^0x22^0x33 = 0x0D
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    check("nobp_fifo3", fifo_count, 3);
    send_cmd(2'd1, 6'd3);
    check("nobp_latency_pv", pkt_valid, 0);
    tick();
    bytes_q = '{8'h11, 8'h22, 8'h33};
    beats("nobp", 8'h0D);
    check("nobp_pkt_count", pkt_count, 1);
    check("nobp_fifo_empty", fifo_count, 0);

    // Busy stalls on header and parity beats
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    send_cmd(2'd1, 6'd3);
    tick();
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hdr", data_out, 8'h0D);
      check("stall_hdr_pv", pkt_valid, 1);
    end
    busy = 1'b0;
    tick(); check("stall_b0", data_out, 8'h11);
    tick(); check("stall_b1", data_out, 8'h22);
    tick(); check("stall_b2", data_out, 8'h33);
    tick(); check("stall_par", data_out, 8'h0D);
    busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stall_par_hold", data_out, 8'h0D);
      check("stall_par_pv", pkt_valid, 0);
      check("stall_par_count", pkt_count, 1);
    end
    busy = 1'b0;
    tick();
    check("stall_gap_data", data_out, 0);
    check("stall_pkt_count", pkt_count, 2);
    tick();

    // Late payload: header {4,2}=0x12 one cycle after fifo_count reaches 4
    send_cmd(2'd2, 6'd4);
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 0) begin
        pl_valid = 1'b1;
        pl_data  = b4[i/3];
      end
      tick();
      pl_valid = 1'b0;
      check("late_wait_pv", pkt_valid, 0);
      check("late_wait_active", tx_active, 0);
    end
    check("late_fifo4", fifo_count, 4);
    tick();
    bytes_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    beats("late", 8'h12);
    check("late_pkt_count", pkt_count, 3);

    // Illegal commands leave the FIFO alone
    push_byte(8'h5A); push_byte(8'hA5);
    send_cmd(2'd3, 6'd5);
    check("ill_a_err", cmd_err, 1);
    check("ill_a_pv", pkt_valid, 0);
    check("ill_a_idle", cmd_ready, 1);
    tick();
    check("ill_a_err_clr", cmd_err, 0);
    send_cmd(2'd0, 6'd0);
    check("ill_b_err", cmd_err, 1);
    check("ill_b_pv", pkt_valid, 0);
    tick();
    check("ill_b_err_clr", cmd_err, 0);
    check("ill_fifo", fifo_count, 2);
    send_cmd(2'd0, 6'd2);
    tick();
    bytes_q = '{8'h5A, 8'hA5};
    beats("ill_follow", 8'h08);
    check("ill_pkt_count", pkt_count, 4);

    // Asynchronous reset during PAYLOAD
    push_byte(8'h44); push_byte(8'h55); push_byte(8'h66);
    send_cmd(2'd1, 6'd3);
    tick();
    tick();
    check("mid_in_payload", data_out, 8'h44);
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_pv", pkt_valid, 0);
    check("mid_rst_data", data_out, 0);
    check("mid_rst_fifo", fifo_count, 0);
    check("mid_rst_count", pkt_count, 0);
    check("mid_rst_active", tx_active, 0);
    @(negedge clock);
    resetn = 1'b1;
    tick();
    push_byte(8'h7E);
    send_cmd(2'd1, 6'd1);
    tick();
    bytes_q = '{8'h7E};
    beats("post_rst", 8'h05);
    check("post_rst_count", pkt_count, 1);

    // Back-to-back len=63 packets, second payload streamed during the first
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    tick();
    for (int i = 0; i < 63; i++) push_byte(p1[i]);
    push_byte(p2[0]);
    check("b2b_full_count", fifo_count, 64);
    check("b2b_full_ready", pl_ready, 0);
    begin
      logic [7:0] par;
      logic [7:0] e;
      int  pushed;
      bit  issued;
      bit  prev_pv;
      int  low_run;
      int  seen;
      exp_q.push_back(8'hFC); par = 8'hFC;
      for (int i = 0; i < 63; i++) begin exp_q.push_back(p1[i]); par = par ^ p1[i]; end
      par_q.push_back(par);
      exp_q.push_back(8'hFC); par = 8'hFC;
      for (int i = 0; i < 63; i++) begin exp_q.push_back(p2[i]); par = par ^ p2[i]; end
      par_q.push_back(par);
      send_cmd(2'd0, 6'd63);
      pushed = 1; issued = 0; prev_pv = 0; low_run = 0; seen = 0;
      for (int cyc = 0; cyc < 600 && pkt_count != 16'd2; cyc++) begin
        if (fifo_count == 7'd64) check("b2b_ready_full", pl_ready, 0);
        pl_valid  = (pushed < 63) && pl_ready;
        pl_data   = (pushed < 63) ? p2[pushed] : 8'h00;
        cmd_valid = !issued && cmd_ready && (pkt_count == 16'd1);
        cmd_addr  = 2'd0;
        cmd_len   = 6'd63;
        tick();
        if (pl_valid) pushed++;
        if (cmd_valid) issued = 1;
        pl_valid = 1'b0;
        cmd_valid = 1'b0;
        if (pkt_valid) begin
          if (!prev_pv && seen > 0) check("b2b_gap", 32'(low_run >= 2), 1);
          if (!prev_pv) seen++;
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
          check("b2b_beat", data_out, e);
          low_run = 0;
        end else begin
          if (prev_pv) begin
            e = (par_q.size() != 0) ? par_q.pop_front() : 8'hxx;
            check("b2b_par", data_out, e);
          end
          low_run++;
        end
        prev_pv = pkt_valid;
      end
      check("b2b_pkt_count", pkt_count, 2);
      check("b2b_beats_left", exp_q.size(), 0);
      check("b2b_par_left", par_q.size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
